// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbiter for two byte producers plus a fixed-length burst
// read sequencer for a 16x8 FIFO; tracks FIFO occupancy internally.
module fifo_rr_ctrl #(
  parameter int BURST = 4,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       fifo_w_en,
  output logic [7:0] fifo_data_w,
  input  logic       fifo_full,
  output logic       fifo_r_en,
  input  logic [7:0] fifo_data_r,
  input  logic       sink_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [4:0] level,
  output logic       busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);
  localparam logic [4:0] BURST_L = 5'(BURST);
  localparam logic [CW-1:0] CNT_INIT = CW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, READ, TAIL} state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic r_en_next, busy_next, last_next;
  logic prio;
  logic grant_a, grant_b, wr_ok;

  // prio = 0 favours A on contention, 1 favours B.
  always_comb begin
    grant_a     = a_valid && (!b_valid || !prio);
    grant_b     = b_valid && (!a_valid || prio);
    wr_ok       = (level < DEPTH_L) && !fifo_full && !rst;
    a_ready     = grant_a && wr_ok;
    b_ready     = grant_b && wr_ok;
    fifo_w_en   = a_ready || b_ready;
    fifo_data_w = grant_a ? a_data : (grant_b ? b_data : 8'h00);
  end

  assign out_data = fifo_data_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio  <= 1'b0;
      level <= 5'd0;
    end else begin
      if (fifo_w_en) prio <= a_ready;
      case ({fifo_w_en, fifo_r_en})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    r_en_next  = 1'b0;
    busy_next  = busy;
    last_next  = 1'b0;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (level >= BURST_L && sink_ready) begin
          state_next = READ;
          r_en_next  = 1'b1;
          cnt_next   = CNT_INIT;
          busy_next  = 1'b1;
        end
      end
      READ: begin
        busy_next = 1'b1;
        if (cnt == '0) begin
          state_next = TAIL;
          last_next  = 1'b1;
        end else begin
          r_en_next = 1'b1;
          cnt_next  = cnt - 1'b1;
        end
      end
      TAIL: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Read data is registered inside the fifo, so out_valid trails r_en by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fifo_r_en <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      fifo_r_en <= r_en_next;
      busy      <= busy_next;
      out_valid <= fifo_r_en;
      out_last  <= last_next;
    end
  end

endmodule
